// File: rtl/output_argmax_ctrl.sv
// MLP output stage: snapshots all output neurons on the rising edge of `done`,
// scans them through one signed comparator and reports the winning class.
module output_argmax_ctrl #(
  parameter int NUM_OUT = 10,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      done,
  input  logic [NUM_OUT*DATA_W-1:0] in_bus,
  output logic                      busy,
  output logic                      finished,
  output logic [IDX_W-1:0]          class_idx,
  output logic [DATA_W-1:0]         max_val,
  output logic                      overrun,
  output logic                      state_dbg
);

  // Handshake: `done` is a level; only its rising edge in IDLE starts a frame.
  // `finished` is a one-cycle strobe with class_idx/max_val valid alongside it;
  // there is no back-pressure, and edges arriving while busy only set `overrun`.

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

  state_t              state, state_nx;
  logic                prev_done;
  logic                rise;
  logic                start, step, last;
  logic [DATA_W-1:0]   snap [NUM_OUT];
  logic [DATA_W-1:0]   best_val;
  logic [IDX_W-1:0]    best_idx;
  logic [IDX_W-1:0]    cnt;
  logic [DATA_W-1:0]   cand;
  logic                greater;

  assign rise      = done & ~prev_done;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (rise) state_nx = SCAN;
      SCAN: if (cnt == LAST_IDX) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start   = (state == IDLE) && rise;
    step    = (state == SCAN);
    last    = step && (cnt == LAST_IDX);
    cand    = snap[cnt];
    greater = $signed(cand) > $signed(best_val);
  end

  // Snapshot is pure data; it is only read while scanning, so no reset needed.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int k = 0; k < NUM_OUT; k++) snap[k] <= in_bus[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_done <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      class_idx <= '0;
      max_val   <= '0;
      overrun   <= 1'b0;
      cnt       <= '0;
      best_val  <= '0;
      best_idx  <= '0;
    end else begin
      prev_done <= done;
      finished  <= 1'b0;
      // Includes the final scan cycle, where busy is still high.
      if (rise && state == SCAN) overrun <= 1'b1;
      if (start) begin
        best_val <= in_bus[DATA_W-1:0];
        best_idx <= '0;
        cnt      <= IDX_W'(1);
        busy     <= 1'b1;
      end
      if (step) begin
        // Strictly greater only, so ties keep the lower index.
        if (greater) begin
          best_val <= cand;
          best_idx <= cnt;
        end
        cnt <= cnt + 1'b1;
        if (last) begin
          class_idx <= greater ? cnt  : best_idx;
          max_val   <= greater ? cand : best_val;
          finished  <= 1'b1;
          busy      <= 1'b0;
          cnt       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_output_argmax_ctrl.sv
// Bench for output_argmax_ctrl: frames are driven with expected winners queued,
// and a negedge monitor pops and compares them when `finished` pulses.
module tb_output_argmax_ctrl;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int EW = 32 + IW + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic              done;
  logic [N*DW-1:0]   in_bus;
  logic              busy;
  logic              finished;
  logic [IW-1:0]     class_idx;
  logic [DW-1:0]     max_val;
  logic              overrun;
  logic              state_dbg;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  logic [EW-1:0]        exp_q[$];
  logic signed [DW-1:0] frame_v [N];

  output_argmax_ctrl #(.NUM_OUT(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .done(done), .in_bus(in_bus),
    .busy(busy), .finished(finished), .class_idx(class_idx),
    .max_val(max_val), .overrun(overrun), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference argmax: first occurrence of the largest signed value.
  function automatic logic [IW+DW-1:0] model();
    logic signed [DW-1:0] bv;
    logic [IW-1:0]        bi;
    bv = frame_v[0];
    bi = '0;
    for (int k = 1; k < N; k++) begin
      if (frame_v[k] > bv) begin
        bv = frame_v[k];
        bi = IW'(k);
      end
    end
    return {bi, bv};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus();
    for (int k = 0; k < N; k++) in_bus[k*DW +: DW] = frame_v[k];
  endtask

  // Edge is sampled at the next clock (E0); finished is seen N cycles later.
  task automatic drive_frame();
    set_bus();
    done = 1'b1;
    exp_q.push_back({32'(cyc + N), model()});
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
  endtask

  task automatic rand_frame();
    for (int k = 0; k < N; k++) frame_v[k] = DW'($urandom_range(0, 65535));
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (finished) begin
      if (exp_q.size() == 0) begin
        check("spurious_finished", 32'(finished), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("latency", cyc, e[EW-1:IW+DW]);
        check("class_idx", 32'(class_idx), 32'(e[IW+DW-1:DW]));
        check("max_val", 32'(max_val), 32'(e[DW-1:0]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    done = 1'b0;
    in_bus = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_finished", 32'(finished), 0);
    check("rst_class_idx", 32'(class_idx), 0);
    check("rst_max_val", 32'(max_val), 0);
    check("rst_overrun", 32'(overrun), 0);
    tick();

    // basic frame, done held high throughout
    for (int k = 0; k < N; k++) frame_v[k] = '0;
    frame_v[1] = 16'sd5;
    frame_v[2] = 16'sd3;
    drive_frame();
    tick();
    check("basic_busy", 32'(busy), 1);
    drain();
    repeat (5) tick();
    done = 1'b0;
    tick();

    // all negative
    frame_v = '{-16'sd100, -16'sd3, -16'sd50, -16'sd20, -16'sd8,
                -16'sd9, -16'sd60, -16'sd4, -16'sd11, -16'sd7};
    drive_frame();
    tick();
    done = 1'b0;
    drain();

    // ties and extremes
    for (int k = 0; k < N; k++) frame_v[k] = 16'sh8000;
    frame_v[2] = 16'sh7FFF;
    frame_v[7] = 16'sh7FFF;
    drive_frame();
    tick();
    done = 1'b0;
    drain();

    // reset mid-scan
    rand_frame();
    drive_frame();
    tick();
    done = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_class_idx", 32'(class_idx), 0);
    check("midrst_max_val", 32'(max_val), 0);
    check("midrst_finished", 32'(finished), 0);
    rst = 1'b0;
    repeat (12) tick();
    rand_frame();
    drive_frame();
    tick();
    done = 1'b0;
    drain();

    // snapshot and overrun
    rand_frame();
    drive_frame();
    tick();
    rand_frame();
    set_bus();
    done = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("overrun_scan", 32'(overrun), 1);
    drain();
    repeat (3) tick();
    check("overrun_sticky", 32'(overrun), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("overrun_rst", 32'(overrun), 0);
    tick();

    // back-to-back: second edge on the cycle after finished
    rand_frame();
    drive_frame();
    tick();
    done = 1'b0;
    repeat (N - 1) tick();
    check("b2b_first_finished", 32'(finished), 1);
    rand_frame();
    drive_frame();
    tick();
    check("b2b_busy", 32'(busy), 1);
    done = 1'b0;
    drain();
    check("b2b_overrun", 32'(overrun), 0);

    // overrun on the final scan cycle
    rand_frame();
    drive_frame();
    tick();
    done = 1'b0;
    repeat (N - 2) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    drain();
    check("last_cycle_overrun", 32'(overrun), 1);

    // random frames, including ties at the ends
    for (int t = 0; t < 4; t++) begin
      rand_frame();
      if (t == 1) frame_v[N-1] = frame_v[0];
      drive_frame();
      tick();
      done = 1'b0;
      drain();
    end

    // done held high across reset release
    rand_frame();
    set_bus();
    rst = 1'b1;
    done = 1'b1;
    tick();
    rst = 1'b0;
    drive_frame();
    tick();
    check("post_rst_edge_busy", 32'(busy), 1);
    drain();
    done = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_argmax_ctrl.md
# output_argmax_ctrl

Controller for the MLP output stage. It detects the rising edge of the final layer's `done` and snapshots all `NUM_OUT` output-neuron values. It then scans them sequentially through a single signed comparator to find the winning class. It reports the class index and value with a one-cycle `finished` pulse, replacing the single-value pass-through used at the end of the network.

## Interface
- `NUM_OUT`, 10: number of output neurons; must be ≥ 2.
- `DATA_W`, 16: width of each neuron value; signed two's complement.
- `IDX_W`, 4: width of class index; must satisfy 2^IDX_W ≥ `NUM_OUT`.

- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `done` input 1: level from last layer; its rising edge starts a frame.
- `in_bus` input `NUM_OUT*DATA_W`: flattened neuron outputs; neuron k occupies bits [k*DATA_W +: DATA_W].
- `busy` output 1: high while scanning.
- `finished` output 1: one-cycle pulse when the result is valid.
- `class_idx` output `IDX_W`: index of the maximum value.
- `max_val` output `DATA_W`: value at `class_idx`, signed.
- `overrun` output 1: sticky; set when a `done` rising edge arrives while busy.

## Operation
- Edge detect:
  - `prev_done` register, reset 0.
  - An edge is `done & ~prev_done`.
  - `prev_done <= done` every cycle.
- FSM states:
  - IDLE → SCAN on edge.
  - SCAN → IDLE after the last element is compared.
  - `rst` → IDLE from any state.
- On the edge in IDLE:
  - Snapshot all of `in_bus` into an internal register array.
  - `best_val <= in_bus[0]`, `best_idx <= 0`, `cnt <= 1`, `busy <= 1`.
  - Later changes on `in_bus` do not affect the frame.
- Each SCAN cycle:
  - Compare `snap[cnt]` to `best_val` as signed values.
  - Replace `best_val`/`best_idx` only if strictly greater. Ties keep the lower index.
  - Increment `cnt`.
- Last element (`cnt == NUM_OUT-1`):
  - Register the final winner into `class_idx`/`max_val`.
  - `finished <= 1`, `busy <= 0`, return to IDLE.
- `class_idx`/`max_val` hold their values until the next frame completes.
- A `done` edge while busy:
  - The edge is ignored; the frame continues unaffected.
  - `overrun <= 1`, cleared only by `rst`.
- A `done` edge on the same cycle the FSM returns to IDLE is also ignored (busy is still set on that edge) and sets `overrun`.
- Reset values: `busy`, `finished`, `class_idx`, `max_val`, `overrun`, `prev_done`, `cnt`, `best_*` all 0.
- Reset mid-scan:
  - The frame is abandoned; no `finished` pulse.
  - Outputs return to 0.
- `done` held high across reset release counts as a rising edge on the first post-reset cycle, because `prev_done` resets to 0.

## Timing
- Edge sampled at clock edge E0 (done=1, prev_done=0): `busy` high after E0.
- Comparisons occur at E1 … E(`NUM_OUT`-1).
- `finished`, `class_idx`, `max_val` update at E(`NUM_OUT`-1); `finished` is high for exactly that one following cycle.
- Latency from E0 to `finished`: `NUM_OUT`-1 cycles (9 for default).
- Minimum spacing between accepted frames: `NUM_OUT` cycles. A new edge is accepted at the earliest on the clock edge after `finished` rises.
- `done` must return low for at least one cycle to generate a new edge.
- No combinational path from inputs to outputs.

## Test plan
- Basic frame:
  - Stimulus: `in_bus` = {0,5,3,…,0} (neuron1=5 max); raise `done` and hold.
  - Response: `finished` is a single pulse 9 cycles after edge; `class_idx`=1, `max_val`=5; exactly one pulse despite `done` staying high.
- All negative:
  - Stimulus: values −100,−3,−50,…,−7 with neuron1=−3.
  - Response: `class_idx`=1, `max_val`=16'hFFFD; signed compare confirmed.
- Ties and extremes:
  - Stimulus: neurons 2 and 7 both 16'h7FFF; others 16'h8000.
  - Response: `class_idx`=2, `max_val`=16'h7FFF.
- Snapshot and overrun:
  - Stimulus: change `in_bus` and toggle `done` low/high during SCAN.
  - Response: result reflects the original snapshot; `overrun`=1 and stays 1; no extra `finished`; after reset `overrun`=0.
- Reset mid-scan:
  - Stimulus: assert `rst` at cycle 4 of SCAN.
  - Response: next cycle `busy`=0, `class_idx`=0, `max_val`=0; no `finished`.
  - Follow-up: next `done` edge gives a correct full frame.
- Back-to-back:
  - Stimulus: second `done` edge on the cycle after `finished`.
  - Response: accepted; second result correct; `overrun` stays 0.
